// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and enums for the memory port arbiter (package riscv_pkg).
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int AW   = 32;

    typedef enum logic [0:0] {
        REQ_IF = 1'b0,
        REQ_D  = 1'b1
    } req_id_e;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, load/store and memory-side signals of the arbiter; slave = arbiter side.
interface mem_port_arbiter_if #(
    parameter int XLEN = riscv_pkg::XLEN,
    parameter int AW   = riscv_pkg::AW
);
    logic              if_req;
    logic [AW-1:0]     if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [XLEN-1:0]   if_rdata;

    logic              d_req;
    logic              d_we;
    logic [XLEN/8-1:0] d_be;
    logic [AW-1:0]     d_addr;
    logic [XLEN-1:0]   d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [XLEN-1:0]   d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [XLEN/8-1:0] mem_be;
    logic [AW-1:0]     mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN-1:0]   mem_rdata;

    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        input  mem_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_be, d_addr, d_wdata,
        output mem_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter_arb_pick2.sv
// Combinational 2-way picker; bit 0 = fetch, bit 1 = data. Round-robin when ARB_RR_EN is defined.
module arb_pick2
    import riscv_pkg::*;
(
    input  logic [1:0] req,
`ifdef ARB_RR_EN
    input  req_id_e    last_winner,
`endif
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
`ifdef ARB_RR_EN
            gnt = (last_winner == REQ_IF) ? 2'b10 : 2'b01;
`else
            gnt = 2'b10;
`endif
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between fetch and load/store.
// Optional round-robin arbitration: define ARB_RR_EN.
//
// state    | meaning
// ARB_IDLE | no access outstanding
// ARB_WAIT | access outstanding; cnt counts down to the response cycle (cnt==1)
module mem_port_arbiter
    import riscv_pkg::*;
#(
    parameter int MEM_LATENCY = 1
) (
    input  logic              CLK,
    input  logic              Reset,
    mem_port_arbiter_if.slave bus
);

    localparam int             CW       = $clog2(MEM_LATENCY + 1);
    localparam logic [CW-1:0]  CNT_LOAD = CW'(MEM_LATENCY);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    arb_state_e    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    req_id_e       owner, owner_nxt;

    logic [1:0]    req_vec;
    logic [1:0]    pick;
    req_id_e       winner;
    logic          resp;
    logic          issue;

    assign req_vec = {bus.d_req, bus.if_req};
    assign winner  = pick[1] ? REQ_D : REQ_IF;
    // Response cycle doubles as a grant slot, giving one access per MEM_LATENCY cycles.
    assign resp    = (state == ARB_WAIT) && (cnt == CNT_ONE) && !Reset;
    assign issue   = ((state == ARB_IDLE) || resp) && (|req_vec) && !Reset;

`ifdef ARB_RR_EN
    req_id_e last_winner;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            last_winner <= REQ_IF;
        end else if (issue) begin
            last_winner <= winner;
        end
    end

    arb_pick2 u_pick (
        .req         (req_vec),
        .last_winner (last_winner),
        .gnt         (pick)
    );
`else
    arb_pick2 u_pick (
        .req (req_vec),
        .gnt (pick)
    );
`endif

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state <= ARB_IDLE;
            cnt   <= '0;
            owner <= REQ_IF;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            owner <= owner_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        owner_nxt     = owner;
        bus.if_gnt    = 1'b0;
        bus.d_gnt     = 1'b0;
        bus.if_rvalid = 1'b0;
        bus.d_rvalid  = 1'b0;
        bus.if_rdata  = bus.mem_rdata;
        bus.d_rdata   = bus.mem_rdata;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_be    = '0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;

        if (state == ARB_WAIT) begin
            if (resp) begin
                state_nxt = ARB_IDLE;
                cnt_nxt   = '0;
                if (owner == REQ_D) begin
                    bus.d_rvalid = 1'b1;
                end else begin
                    bus.if_rvalid = 1'b1;
                end
            end else begin
                cnt_nxt = cnt - CNT_ONE;
            end
        end

        if (issue) begin
            state_nxt  = ARB_WAIT;
            cnt_nxt    = CNT_LOAD;
            owner_nxt  = winner;
            bus.mem_en = 1'b1;
            if (winner == REQ_D) begin
                bus.d_gnt     = 1'b1;
                bus.mem_we    = bus.d_we;
                bus.mem_be    = bus.d_be;
                bus.mem_addr  = bus.d_addr;
                bus.mem_wdata = bus.d_wdata;
            end else begin
                bus.if_gnt   = 1'b1;
                bus.mem_be   = '1;
                bus.mem_addr = bus.if_addr;
            end
        end
    end

endmodule
